simplebus_mem_arbiter: RTL

// - Shares the single cached-memory SimpleBus port among N requesters (I-cache io_out_mem, D-cache io_out_mem).
// - Round-robin grant, held for one whole transaction (all request beats, then all response beats).
// - Sits between the Cache instances and the memory crossbar; at most one transaction is outstanding.

---
 rtl/simplebus_pkg.sv | 21 ++
 rtl/simplebus_mem_arbiter_rr_picker.sv | 32 +++
 rtl/simplebus_mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/simplebus_pkg.sv
// SimpleBus command codes and arbiter state encoding shared by the memory-side arbiter.
package simplebus_pkg;

  localparam logic [3:0] CMD_READ     = 4'b0000;
  localparam logic [3:0] CMD_WRITE    = 4'b0001;
  localparam logic [3:0] CMD_RD_BURST = 4'b0010;
  localparam logic [3:0] CMD_WR_BURST = 4'b0011;
  localparam logic [3:0] CMD_WR_LAST  = 4'b0111;
  localparam logic [3:0] CMD_RD_LAST  = 4'b0110;
  localparam logic [3:0] CMD_WR_RESP  = 4'b0101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Only these two response codes close a transaction; everything else is a data beat.
  function automatic logic is_resp_last(input logic [3:0] cmd);
    return (cmd == CMD_RD_LAST) || (cmd == CMD_WR_RESP);
  endfunction

endpackage

// File: rtl/simplebus_mem_arbiter_rr_picker.sv
// Combinational round-robin select: first valid requester at or after i_ptr, wrapping.
module rr_picker #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [ID_W-1:0]  o_idx
);

  int               w_pos;
  logic [N_REQ-1:0] w_sel;

  // Walk from farthest to nearest so the closest valid requester to i_ptr wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_pos    = 0;
    w_sel    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      w_sel = i_valid >> w_pos;
      if (w_sel[0]) begin
        o_idx    = ID_W'(w_pos);
        o_onehot = N_REQ'(1) << w_pos;
      end
    end
  end

endmodule

// File: rtl/simplebus_mem_arbiter.sv
// Round-robin arbiter sharing one SimpleBus memory port among N_REQ cache requesters,
// holding the grant for a whole transaction with no buffering.
module simplebus_mem_arbiter
  import simplebus_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 64,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int MASK_W = DATA_W / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          in_req_valid,
  output logic [N_REQ-1:0]          in_req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   in_req_addr,
  input  logic [N_REQ*3-1:0]        in_req_size,
  input  logic [N_REQ*4-1:0]        in_req_cmd,
  input  logic [N_REQ*MASK_W-1:0]   in_req_wmask,
  input  logic [N_REQ*DATA_W-1:0]   in_req_wdata,
  output logic [N_REQ-1:0]          in_resp_valid,
  input  logic [N_REQ-1:0]          in_resp_ready,
  output logic [3:0]                in_resp_cmd,
  output logic [DATA_W-1:0]         in_resp_rdata,
  output logic                      out_req_valid,
  input  logic                      out_req_ready,
  output logic [ADDR_W-1:0]         out_req_addr,
  output logic [2:0]                out_req_size,
  output logic [3:0]                out_req_cmd,
  output logic [MASK_W-1:0]         out_req_wmask,
  output logic [DATA_W-1:0]         out_req_wdata,
  input  logic                      out_resp_valid,
  output logic                      out_resp_ready,
  input  logic [3:0]                out_resp_cmd,
  input  logic [DATA_W-1:0]         out_resp_rdata,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [3:0]        cmd;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [7:0]       r_beat_cnt;

  req_t [N_REQ-1:0] w_req;
  req_t             w_cur;
  logic [N_REQ-1:0] w_pick_oh;
  logic [ID_W-1:0]  w_pick_idx;
  logic             w_pick_any;
  logic             w_in_req;
  logic             w_in_resp;
  logic             w_req_fire;
  logic             w_resp_fire;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .i_valid  (in_req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  assign w_pick_any = |w_pick_oh;
  assign w_in_req   = (r_state == ST_REQ);
  assign w_in_resp  = (r_state == ST_RESP);

  // Per-requester unpacking and handshake steering; only the grantee ever sees a ready/valid.
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign w_req[g] = {in_req_addr[g*ADDR_W +: ADDR_W], in_req_size[g*3 +: 3],
                       in_req_cmd[g*4 +: 4], in_req_wmask[g*MASK_W +: MASK_W],
                       in_req_wdata[g*DATA_W +: DATA_W]};
    assign in_req_ready[g]  = w_in_req  & (r_grant_id == ID_W'(g)) & out_req_ready;
    assign in_resp_valid[g] = w_in_resp & (r_grant_id == ID_W'(g)) & out_resp_valid;
  end

  assign w_cur          = w_req[r_grant_id];
  assign out_req_valid  = w_in_req & in_req_valid[r_grant_id];
  assign out_req_addr   = w_cur.addr;
  assign out_req_size   = w_cur.size;
  assign out_req_cmd    = w_cur.cmd;
  assign out_req_wmask  = w_cur.wmask;
  assign out_req_wdata  = w_cur.wdata;
  assign out_resp_ready = w_in_resp & in_resp_ready[r_grant_id];
  assign in_resp_cmd    = out_resp_cmd;
  assign in_resp_rdata  = out_resp_rdata;
  assign busy           = w_in_req | w_in_resp;
  assign grant_id       = r_grant_id;

  assign w_req_fire  = out_req_valid & out_req_ready;
  assign w_resp_fire = out_resp_valid & out_resp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Write bursts keep the request channel until the closing WR_LAST beat.
          if (w_req_fire && (w_cur.cmd != CMD_WR_BURST)) begin
            r_state    <= ST_RESP;
            r_beat_cnt <= '0;
          end
        end
        ST_RESP: begin
          if (w_resp_fire) begin
            if (r_beat_cnt != 8'hFF) r_beat_cnt <= r_beat_cnt + 8'd1;
            if (is_resp_last(out_resp_cmd)) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
